// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_pkg: shared encodings for the main-memory arbiter      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ACC  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_MEM_LAT = 4;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_lat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lat_cnt: loadable 4-bit down-counter with zero flag                |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module lat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] loadVal,
  output logic       zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= loadVal;
    end else if (en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule : lat_cnt
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter: round-robin I/D cache arbiter for fixed-latency memory|
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wline,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_rline,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam logic [3:0] c_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_we;
  logic              r_lastD;
  logic              r_memRe;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [LINE_W-1:0] r_memWdata;
  logic              r_iRdy;
  logic              r_dRdy;
  logic [LINE_W-1:0] r_iLine;
  logic [LINE_W-1:0] r_dRline;

  logic w_anyReq;
  logic w_grantD;
  logic w_load;
  logic w_cntEn;
  logic w_zero;

  // On a tie, D wins unless D was the last one served.
  assign w_anyReq = i_req | d_req;
  assign w_grantD = d_req & (~i_req | ~r_lastD);
  assign w_load   = (r_state == ARB_IDLE) & w_anyReq;
  assign w_cntEn  = (r_state == ARB_ACC);

  lat_cnt u_latCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .en      (w_cntEn),
    .loadVal (c_LOAD),
    .zero    (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_I;
      r_we       <= 1'b0;
      r_lastD    <= 1'b0;
      r_memRe    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_iRdy     <= 1'b0;
      r_dRdy     <= 1'b0;
      r_iLine    <= '0;
      r_dRline   <= '0;
    end else begin
      r_iRdy <= 1'b0;
      r_dRdy <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_anyReq) begin
            r_owner   <= w_grantD ? OWN_D : OWN_I;
            r_we      <= w_grantD & d_we;
            r_memAddr <= w_grantD ? d_addr : i_addr;
            if (w_grantD) begin
              r_memWdata <= d_wline;
            end
            r_memRe <= ~(w_grantD & d_we);
            r_memWe <= w_grantD & d_we;
            r_state <= ARB_ACC;
          end
        end
        ARB_ACC: begin
          // Read data is only valid in the final strobe cycle.
          if (w_zero) begin
            r_memRe <= 1'b0;
            r_memWe <= 1'b0;
            if (r_owner == OWN_D) begin
              r_dRdy <= 1'b1;
              if (!r_we) begin
                r_dRline <= mem_rdata;
              end
            end else begin
              r_iRdy  <= 1'b1;
              r_iLine <= mem_rdata;
            end
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          r_lastD <= (r_owner == OWN_D);
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign i_rdy     = r_iRdy;
  assign i_line    = r_iLine;
  assign d_rdy     = r_dRdy;
  assign d_rline   = r_dRline;
  assign mem_re    = r_memRe;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter       |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [13:0] i_addr, d_addr;
  logic [63:0] d_wline, rdata;
  logic        i_rdy, d_rdy, mem_re, mem_we;
  logic [63:0] i_line, d_rline, mem_wdata;
  logic [13:0] mem_addr;

  // Second instance with single-cycle memory
  logic        rst1_n, i_req1;
  logic [13:0] i_addr1;
  logic [63:0] rdata1;
  logic        i_rdy1, d_rdy1, mem_re1, mem_we1;
  logic [63:0] i_line1, d_rline1, mem_wdata1;
  logic [13:0] mem_addr1;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(14), .LINE_W(64), .MEM_LAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_line(i_line),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline),
    .d_rdy(d_rdy), .d_rline(d_rline),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata)
  );

  mem_arbiter #(.ADDR_W(14), .LINE_W(64), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdy(i_rdy1), .i_line(i_line1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(14'h0), .d_wline(64'h0),
    .d_rdy(d_rdy1), .d_rline(d_rline1),
    .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(rdata1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Both caches request at once (D fill, I fill); D must go first.
  task automatic tieRound(input logic [13:0] da, input logic [13:0] ia,
                          input logic [63:0] dd, input logic [63:0] id);
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    i_req = 1'b1; i_addr = ia;
    rdata = dd;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("tie d mem_re", mem_re, 1);
      chk("tie d mem_addr", mem_addr, da);
      chk("tie d i_rdy", i_rdy, 0);
    end
    tick();
    chk("tie d_rdy", d_rdy, 1);
    chk("tie i_rdy early", i_rdy, 0);
    chk("tie d_rline", d_rline, dd);
    d_req = 1'b0;
    rdata = id;
    tick();
    chk("tie gap mem_re", mem_re, 0);
    chk("tie gap d_rdy", d_rdy, 0);
    for (int c = 7; c <= 10; c++) begin
      tick();
      chk("tie i mem_re", mem_re, 1);
      chk("tie i mem_addr", mem_addr, ia);
      chk("tie i i_rdy", i_rdy, 0);
    end
    tick();
    chk("tie i_rdy", i_rdy, 1);
    chk("tie i_line", i_line, id);
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wline = '0; rdata = '0;
    rst1_n = 1'b0; i_req1 = 1'b0; i_addr1 = '0; rdata1 = '0;
    tick();
    tick();

    chk("rst mem_re", mem_re, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst i_rdy", i_rdy, 0);
    chk("rst d_rdy", d_rdy, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst i_line", i_line, 0);
    chk("rst d_rline", d_rline, 0);
    rst_n = 1'b1;
    tick();

    // Single I fill
    i_req = 1'b1; i_addr = 14'h0010; rdata = 64'h1111_2222_3333_4444;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("ifill mem_re", mem_re, 1);
      chk("ifill mem_we", mem_we, 0);
      chk("ifill mem_addr", mem_addr, 14'h0010);
      chk("ifill i_rdy", i_rdy, 0);
      chk("ifill d_rdy", d_rdy, 0);
    end
    tick();
    chk("ifill i_rdy pulse", i_rdy, 1);
    chk("ifill mem_re off", mem_re, 0);
    chk("ifill d_rdy", d_rdy, 0);
    chk("ifill i_line", i_line, 64'h1111_2222_3333_4444);
    i_req = 1'b0;
    tick();
    chk("ifill i_rdy end", i_rdy, 0);

    // D writeback
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0A00; d_wline = 64'hDEAD_BEEF_CAFE_F00D;
    rdata = 64'h9999_9999_9999_9999;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("dwb mem_we", mem_we, 1);
      chk("dwb mem_re", mem_re, 0);
      chk("dwb mem_addr", mem_addr, 14'h0A00);
      chk("dwb mem_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("dwb d_rdy", d_rdy, 0);
    end
    tick();
    chk("dwb d_rdy pulse", d_rdy, 1);
    chk("dwb mem_we off", mem_we, 0);
    chk("dwb d_rline", d_rline, 0);
    chk("dwb i_rdy", i_rdy, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Simultaneous requests from reset, then a second tie round
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tieRound(14'h0030, 14'h0020, 64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002);
    tieRound(14'h0031, 14'h0021, 64'hAAAA_0000_AAAA_0003, 64'hBBBB_0000_BBBB_0004);

    // Late I arrival during a D fill
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0040; rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    chk("late c1 mem_addr", mem_addr, 14'h0040);
    tick();
    i_req = 1'b1; i_addr = 14'h0050;
    chk("late c2 mem_addr", mem_addr, 14'h0040);
    for (int c = 3; c <= 4; c++) begin
      tick();
      chk("late d mem_addr", mem_addr, 14'h0040);
      chk("late d mem_re", mem_re, 1);
    end
    tick();
    chk("late d_rdy", d_rdy, 1);
    chk("late d_rline", d_rline, 64'h0123_4567_89AB_CDEF);
    d_req = 1'b0;
    rdata = 64'hFEDC_BA98_7654_3210;
    tick();
    for (int c = 7; c <= 10; c++) begin
      tick();
      chk("late i mem_addr", mem_addr, 14'h0050);
      chk("late i i_rdy", i_rdy, 0);
    end
    tick();
    chk("late i_rdy c11", i_rdy, 1);
    chk("late i_line", i_line, 64'hFEDC_BA98_7654_3210);
    i_req = 1'b0;
    tick();

    // Reset in the middle of an I read
    i_req = 1'b1; i_addr = 14'h0060; rdata = 64'h7777_7777_7777_7777;
    tick();
    chk("midrst c1 mem_re", mem_re, 1);
    tick();
    rst_n = 1'b0; i_req = 1'b0;
    tick();
    chk("midrst mem_re", mem_re, 0);
    chk("midrst mem_we", mem_we, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst i_rdy", i_rdy, 0);
    chk("midrst i_line", i_line, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst quiet i_rdy", i_rdy, 0);
      chk("midrst quiet mem_re", mem_re, 0);
    end
    i_req = 1'b1; i_addr = 14'h0070; rdata = 64'h2468_ACE0_1357_9BDF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("fresh mem_re", mem_re, 1);
      chk("fresh mem_addr", mem_addr, 14'h0070);
    end
    tick();
    chk("fresh i_rdy", i_rdy, 1);
    chk("fresh i_line", i_line, 64'h2468_ACE0_1357_9BDF);
    i_req = 1'b0;
    tick();

    // MEM_LAT=1 back-to-back I requests
    rst1_n = 1'b1;
    tick();
    i_req1 = 1'b1; i_addr1 = 14'h0011; rdata1 = 64'h5555_6666_7777_8888;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("lat1 mem_re", mem_re1, ((c % 3) == 1));
      chk("lat1 i_rdy", i_rdy1, ((c % 3) == 2));
      chk("lat1 mem_we", mem_we1, 0);
      chk("lat1 d_rdy", d_rdy1, 0);
      if ((c % 3) == 2) begin
        chk("lat1 i_line", i_line1, 64'h5555_6666_7777_8888);
      end
    end
    i_req1 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port unified main memory between the instruction-cache miss path and the data-cache miss/writeback path. Grants one line-sized access at a time and drives a fixed-latency memory for `MEM_LAT` cycles. Returns the line, or a write acknowledge, to the granted requester with a one-cycle ready pulse. Sits between the two cache controllers and the memory model; the pipeline stalls while either cache waits.

## Interface
- `ADDR_W`, 14: line address width (16-bit word address minus 2 offset bits).
- `LINE_W`, 64: line width (4 × 16-bit words).
- `MEM_LAT`, 4: cycles the memory strobe must be held before read data is valid or a write is committed; legal range 1–15.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_req` in 1: I-cache line read request (level).
- `i_addr` in ADDR_W: I-cache line address.
- `i_rdy` out 1: one-cycle pulse; `i_line` valid.
- `i_line` out LINE_W: fetched line; held until next I completion.
- `d_req` in 1: D-cache request (level).
- `d_we` in 1: 1 = dirty-line writeback, 0 = line fill.
- `d_addr` in ADDR_W: D-cache line address.
- `d_wline` in LINE_W: writeback data.
- `d_rdy` out 1: one-cycle pulse; fill data valid, or write committed.
- `d_rline` out LINE_W: fill line; held until next D read completion, unchanged by writes.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory line address.
- `mem_wdata` out LINE_W: memory write data.
- `mem_rdata` in LINE_W: memory read data, valid in the last strobe cycle.

## Operation
- States: `IDLE`, `ACC`, `RESP`.
- `IDLE`:
  - No request: stay in `IDLE`.
  - One request: grant it.
  - Both requests: round-robin; grant the requester not served last (`last_d` flop).
  - On grant: latch owner, address, we and wdata; load counter with `MEM_LAT-1`; go to `ACC`.
- `ACC`:
  - Drive `mem_re` or `mem_we` (never both) with the latched address/data.
  - Decrement the counter each cycle.
  - At counter 0: capture `mem_rdata` (reads only) into the owner's line register; go to `RESP`.
- `RESP`:
  - Pulse the owner's `*_rdy` for one cycle; memory strobes low.
  - Update `last_d`; go to `IDLE`.
  - Requests are not sampled in `RESP`; the requester drops `req` at the end of its ready cycle.
- Requester rules:
  - Hold `req`, address and data stable until `rdy`.
  - Arbiter inputs are only sampled at grant.
- A request asserted during another owner's access waits. Worst-case wait is one full access (`MEM_LAT+2` cycles).
- No preemption; a D writeback followed by a D fill is two separate grants.

## Timing
- Reset values:
  - State `IDLE`, counter 0, `last_d`=0 (first tie goes to D).
  - All strobes, `*_rdy`, `mem_addr`, `mem_wdata`, `i_line` and `d_rline` are 0.
- Reset mid-access: the access is abandoned, the strobe drops in the next cycle, and no `rdy` is issued. Requesters must re-request.
- Latency: `req` sampled in `IDLE` at cycle 0; strobe high in cycles 1..`MEM_LAT`; `rdy` in cycle `MEM_LAT+1`.
- Earliest next grant: `IDLE` in cycle `MEM_LAT+2`, strobe again in `MEM_LAT+3`. Throughput is one access per `MEM_LAT+2` cycles.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared defines file holds:
  - State encodings `ARB_IDLE`/`ARB_ACC`/`ARB_RESP` (2 bits).
  - Owner encodings `OWN_I`/`OWN_D`.
  - Default `MEM_LAT`.
- One natural sub-module, `lat_cnt`: a loadable 4-bit down-counter with `load`, `en` and a `zero` flag. The FSM, latches and round-robin flop stay in `mem_arbiter`.

## Test plan
- Single I fill, `MEM_LAT`=4:
  - Stimulus: `i_req`, `i_addr`=0x0010; memory returns 0x1111_2222_3333_4444.
  - Required: `mem_re` high cycles 1–4 with `mem_addr`=0x0010; `i_rdy` pulse cycle 5; `i_line`=0x1111_2222_3333_4444; `d_rdy` never.
- D writeback:
  - Stimulus: `d_req`, `d_we`=1, `d_addr`=0x0A00, `d_wline`=0xDEAD_BEEF_CAFE_F00D.
  - Required: `mem_we` cycles 1–4 with that data; `d_rdy` cycle 5; `d_rline` unchanged (0).
- Simultaneous requests from reset:
  - Required: D granted first; I granted at cycle 6; I's strobe in cycles 7–10; `i_rdy` cycle 11.
  - Repeated ties alternate D, I, D, I.
- Late arrival: `i_req` rises at cycle 2 of a D access -> `i_rdy` exactly at cycle 11; D's `mem_addr` undisturbed during cycles 1–4.
- Reset mid-access: `rst_n` low in cycle 2 of an I read -> strobes 0 next cycle, state `IDLE`, no `i_rdy`; a fresh request afterwards completes normally.
- `MEM_LAT`=1: back-to-back I requests -> strobe one cycle, `rdy` every 3 cycles, never both strobes high.
